// File: rtl/rx_pkg.sv
// Shared types and SIGNAL-field helpers for the 802.11a serial receive front end.
// Field positions refer to the 24-bit capture word, where bit 23 is the first bit received.
package rx_pkg;

    localparam int PREAMBLE_MIN = 16;
    localparam int SIG_W        = 24;
    localparam int LEN_W        = 12;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SIGNAL = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam int RATE_MSB  = 23;
    localparam int RATE_LSB  = 20;
    localparam int R_POS     = 19;
    localparam int LEN_FIRST = 18;  // LENGTH LSB arrives first
    localparam int PAR_POS   = 6;
    localparam int TAIL_MSB  = 5;

    localparam logic [7:0][3:0] VALID_RATES = {
        4'b1101, 4'b1111, 4'b0101, 4'b0111,
        4'b1001, 4'b1011, 4'b0001, 4'b0011
    };

    function automatic logic rate_ok(input logic [3:0] rate);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++)
            if (VALID_RATES[i] == rate) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [LEN_W-1:0] get_length(input logic [SIG_W-1:0] w);
        logic [LEN_W-1:0] len;
        for (int j = 0; j < LEN_W; j++)
            len[j] = w[LEN_FIRST-j];
        return len;
    endfunction

    // Parity covers RATE, R, LENGTH and the parity bit itself: XOR must be zero.
    function automatic logic sig_ok(input logic [SIG_W-1:0] w);
        return rate_ok(w[RATE_MSB:RATE_LSB]) && !w[R_POS] &&
               !(^w[RATE_MSB:PAR_POS]) && (w[TAIL_MSB:0] == 6'd0) &&
               (get_length(w) != '0);
    endfunction

endpackage

// File: rtl/preamble_detect.sv
// Tracks runs of alternating bits and flags the first repeated bit after a long enough run.
// Counting only happens while enabled; otherwise the run count is held cleared.
module preamble_detect
    import rx_pkg::*;
#(
    parameter int MIN = PREAMBLE_MIN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic brk,
    output logic prev_bit
);
    localparam int CW = $clog2(MIN + 1);

    logic [CW-1:0] alt_cnt;
    logic          same;
    logic          full;

    assign same = (din == prev_bit);
    assign full = (alt_cnt >= CW'(MIN));
    assign brk  = en && same && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit <= 1'b0;
            alt_cnt  <= '0;
        end else begin
            prev_bit <= din;
            if (!en || brk)
                alt_cnt <= '0;
            else if (!same)
                alt_cnt <= full ? alt_cnt : alt_cnt + 1'b1;
            else
                alt_cnt <= CW'(1);
        end
    end

endmodule

// File: rtl/receiver.sv
// 802.11a serial receive front end: preamble hunt, SIGNAL capture/check, payload forwarding.
// Output and Error are registered; every decision uses the bit sampled on the current edge.
module receiver
    import rx_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Input,
    output logic Output,
    output logic Error
);
    state_t             state;
    logic [SIG_W-2:0]   sr;
    logic [4:0]         bit_cnt;
    logic [LEN_W+2:0]   remaining;
    logic [SIG_W-1:0]   word;
    logic               brk;
    logic               prev_bit;

    assign word = {sr, Input};

    preamble_detect #(.MIN(PREAMBLE_MIN)) u_pre (
        .clk      (Clock),
        .rst_n    (Reset),
        .en       (state == HUNT),
        .din      (Input),
        .brk      (brk),
        .prev_bit (prev_bit)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            Output    <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Error  <= 1'b0;
            Output <= (state == DATA) ? Input : 1'b0;
            case (state)
                HUNT: begin
                    // The two equal bits that end the preamble are the first two SIGNAL bits.
                    if (brk) begin
                        state   <= SIGNAL;
                        sr      <= {{(SIG_W-3){1'b0}}, prev_bit, Input};
                        bit_cnt <= 5'd2;
                    end
                end
                SIGNAL: begin
                    sr      <= word[SIG_W-2:0];
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'(SIG_W - 1)) begin
                        if (sig_ok(word)) begin
                            state     <= DATA;
                            remaining <= {get_length(word), 3'b000};
                        end else begin
                            state <= HUNT;
                            Error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == 15'd1) state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: a bit-stream reference model predicts Output/Error per edge.
// Stimulus pushes predictions; a negedge monitor pops and compares.
module tb_receiver;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic Input = 1'b0;
    logic Output, Error;

    receiver dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Input  (Input),
        .Output (Output),
        .Error  (Error)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic o;
        logic e;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    localparam int PRE_MIN = 16;
    localparam int M_HUNT = 0, M_SIG = 1, M_DATA = 2;

    int m_mode, m_run, m_rem;
    bit m_prev;
    bit m_bits[$];

    function automatic void model_reset();
        m_mode = M_HUNT;
        m_run  = 0;
        m_rem  = 0;
        m_prev = 1'b0;
        m_bits.delete();
    endfunction

    function automatic int field_len();
        int len = 0;
        for (int j = 0; j < 12; j++) len += int'(m_bits[5+j]) << j;
        return len;
    endfunction

    function automatic bit sig_pass();
        int rate, ones;
        bit tail_zero;
        rate = 8 * m_bits[0] + 4 * m_bits[1] + 2 * m_bits[2] + m_bits[3];
        ones = 0;
        for (int i = 0; i < 18; i++) ones += m_bits[i];
        tail_zero = 1'b1;
        for (int i = 18; i < 24; i++) if (m_bits[i]) tail_zero = 1'b0;
        return (rate inside {13, 15, 5, 7, 9, 11, 1, 3}) && (m_bits[4] == 1'b0) &&
               (ones % 2 == 0) && tail_zero && (field_len() != 0);
    endfunction

    function automatic exp_t model_step(bit in);
        exp_t r;
        r.o = (m_mode == M_DATA) ? in : 1'b0;
        r.e = 1'b0;
        case (m_mode)
            M_HUNT: begin
                if (in != m_prev) begin
                    if (m_run < PRE_MIN) m_run++;
                end else if (m_run >= PRE_MIN) begin
                    m_mode = M_SIG;
                    m_bits = {m_prev, in};
                end else begin
                    m_run = 1;
                end
            end
            M_SIG: begin
                m_bits.push_back(in);
                if (m_bits.size() == 24) begin
                    if (sig_pass()) begin
                        m_mode = M_DATA;
                        m_rem  = field_len() * 8;
                    end else begin
                        r.e    = 1'b1;
                        m_mode = M_HUNT;
                        m_run  = 0;
                    end
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = M_HUNT;
                    m_run  = 0;
                end
            end
        endcase
        m_prev = in;
        return r;
    endfunction

    task automatic send_bit(input bit b);
        Input = b;
        @(posedge Clock);
        if (!Reset) begin
            model_reset();
            q.push_back('0);
        end else begin
            q.push_back(model_step(b));
        end
        #1;
    endtask

    // Alternating run of n bits whose final bit is 'last'.
    task automatic send_alt(input int n, input bit last);
        for (int i = 0; i < n; i++) send_bit(last ^ bit'((n - 1 - i) % 2));
    endtask

    task automatic send_vec(input logic [23:0] s);
        for (int i = 0; i < 24; i++) send_bit(s[i]);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(bit'($urandom_range(0, 1)));
    endtask

    task automatic send_const(input int n, input bit v);
        for (int i = 0; i < n; i++) send_bit(v);
    endtask

    // Transmit-order vector: s[0] is sent first.
    function automatic logic [23:0] make_sig(input logic [3:0] rate, input logic [11:0] len);
        logic [23:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s[i] = rate[3-i];
        for (int j = 0; j < 12; j++) s[5+j] = len[j];
        s[17] = ^s[16:0];
        return s;
    endfunction

    always @(negedge Clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (Output !== e.o || Error !== e.e) begin
                errors++;
                $display("FAIL out_err t=%0t got Output=%b Error=%b expected Output=%b Error=%b",
                         $time, Output, Error, e.o, e.e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] s;
        logic [3:0]  gr [4];
        logic [3:0]  rate;
        logic [11:0] len;
        int          pl;
        gr = '{4'b1101, 4'b1111, 4'b0001, 4'b0011};
        model_reset();

        // Reset held low with toggling input
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(bit'(i % 2));
        Reset = 1'b1;
        send_const(3, 1'b0);

        // Long preamble + valid SIGNAL (LENGTH=128 -> 1024 payload bits)
        send_alt(96, 1'b0);
        send_vec(24'b000000000001000000001011);
        send_rand(1024);
        send_const(6, 1'b0);

        // Parity bit flipped -> single Error pulse, back to hunting
        s = make_sig(4'b1101, 12'd128);
        s[17] = ~s[17];
        send_alt(96, 1'b0);
        send_vec(s);
        send_const(6, 1'b0);

        // Too-short preamble: no capture
        send_alt(8, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_vec(make_sig(4'b1101, 12'd1));
        send_const(10, 1'b0);

        // LENGTH=1 frame with fixed payload, then another frame right after
        send_alt(32, 1'b0);
        send_vec(make_sig(4'b1101, 12'd1));
        for (int i = 0; i < 8; i++) send_bit(bit'((8'b01001101 >> i) & 8'd1));
        send_const(4, 1'b0);
        send_alt(20, 1'b0);
        send_vec(make_sig(4'b1111, 12'd2));
        send_rand(16);
        send_const(4, 1'b0);

        // Field-corner failures: R set, tail set, LENGTH zero, bad rate
        for (int k = 0; k < 4; k++) begin
            s = make_sig(4'b1101, 12'd3);
            case (k)
                0: begin s[4] = 1'b1; s[17] = ~s[17]; end
                1: s[20] = 1'b1;
                2: s = make_sig(4'b1101, 12'd0);
                default: s = make_sig(4'b1100, 12'd3);
            endcase
            send_alt(18, 1'b0);
            send_vec(s);
            send_const(5, 1'b0);
        end

        // Asynchronous reset mid-payload
        send_alt(40, 1'b0);
        send_vec(make_sig(4'b0011, 12'd4));
        send_const(10, 1'b1);
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        checks++;
        if (Output !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got Output=%b Error=%b expected 0 0", Output, Error);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        Reset = 1'b1;
        send_alt(24, 1'b0);
        send_vec(make_sig(4'b1101, 12'd1));
        send_rand(8);
        send_const(4, 1'b0);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            rate = ($urandom_range(0, 5) == 0) ? 4'($urandom) : gr[$urandom_range(0, 3)];
            len  = 12'($urandom_range(0, 6));
            s    = make_sig(rate, len);
            if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 23)] ^= 1'b1;
            pl = $urandom_range(10, 40);
            send_alt(pl, ~s[0]);
            send_vec(s);
            send_rand(int'(len) * 8);
            send_const($urandom_range(1, 12), 1'b0);
        end

        repeat (3) @(negedge Clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
